// File: rtl/misc_seq_ctrl_if.sv
// Sequencer <-> datapath/memory signal bundle for the MISC-V multi-cycle core.
// The master side is the sequencer: it consumes status/acks and drives strobes.
// The slave side is the datapath and memory environment around it.
interface misc_seq_ctrl_if #(
    parameter int RET_W = 16
);
    logic             i_run;
    logic [2:0]       i_opcode;
    logic             i_branch_taken;
    logic             i_imem_ack;
    logic             i_dmem_ack;

    logic             o_imem_req;
    logic             o_dmem_req;
    logic             o_dmem_we;
    logic             o_ir_we;
    logic             o_pc_inc;
    logic             o_pc_branch;
    logic             o_pc_jump;
    logic             o_reg_we;
    logic             o_retired;
    logic [RET_W-1:0] o_retired_cnt;
    logic             o_bus_error;
    logic [2:0]       o_state;

    modport master (
        input  i_run, i_opcode, i_branch_taken, i_imem_ack, i_dmem_ack,
        output o_imem_req, o_dmem_req, o_dmem_we, o_ir_we, o_pc_inc,
               o_pc_branch, o_pc_jump, o_reg_we, o_retired, o_retired_cnt,
               o_bus_error, o_state
    );

    modport slave (
        output i_run, i_opcode, i_branch_taken, i_imem_ack, i_dmem_ack,
        input  o_imem_req, o_dmem_req, o_dmem_we, o_ir_we, o_pc_inc,
               o_pc_branch, o_pc_jump, o_reg_we, o_retired, o_retired_cnt,
               o_bus_error, o_state
    );
endinterface

// File: rtl/misc_seq_ctrl.sv
// Multi-cycle sequencer for the MISC-V core. Walks the shared datapath through
// FETCH/DECODE/EXEC/MEM/WB, decides when PC, IR, regfile and data memory are
// written, runs the memory req/ack handshakes with a timeout, and counts
// retired instructions. ALU/mux selects come from the separate decoder.
module misc_seq_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4,
    parameter int RET_W       = 16
) (
    input logic           clk,
    input logic           rst_n,
    misc_seq_ctrl_if.master bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd7;

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [TO_W-1:0]  r_wait_cnt;
    logic [RET_W-1:0] r_retired_cnt;

    logic w_in_wait;
    logic w_ack;
    logic w_timeout;
    logic w_is_sw;
    logic w_retire;
    logic w_imem_req;
    logic w_dmem_req;
    logic w_dmem_we;
    logic w_ir_we;
    logic w_pc_inc;
    logic w_pc_branch;
    logic w_pc_jump;
    logic w_reg_we;
    logic w_bus_error;

    assign w_is_sw   = (bus.i_opcode == 3'd3);
    assign w_in_wait = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_ack     = ((r_state == S_FETCH) && bus.i_imem_ack) ||
                       ((r_state == S_MEM)   && bus.i_dmem_ack);
    assign w_timeout = (MEM_TIMEOUT != 0) && (r_wait_cnt == TO_W'(MEM_TIMEOUT));

    // Next-state and strobe decode; ack-qualified strobes fire in the ack cycle itself.
    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        w_imem_req   = 1'b0;
        w_dmem_req   = 1'b0;
        w_dmem_we    = 1'b0;
        w_ir_we      = 1'b0;
        w_pc_inc     = 1'b0;
        w_pc_branch  = 1'b0;
        w_pc_jump    = 1'b0;
        w_reg_we     = 1'b0;
        w_bus_error  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_run) w_next_state = S_FETCH;
            end
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (bus.i_imem_ack) begin
                    w_ir_we      = 1'b1;
                    w_pc_inc     = 1'b1;
                    w_next_state = S_DECODE;
                end else if (w_timeout) begin
                    w_next_state = S_ERROR;
                end
            end
            S_DECODE: begin
                w_next_state = S_EXEC;
            end
            S_EXEC: begin
                case (bus.i_opcode)
                    3'd0, 3'd1: w_next_state = S_WB;
                    3'd2, 3'd3: w_next_state = S_MEM;
                    3'd4, 3'd5: begin
                        w_pc_branch = bus.i_branch_taken;
                        w_retire    = 1'b1;
                    end
                    default: begin
                        w_pc_jump = 1'b1;
                        w_retire  = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = w_is_sw;
                if (bus.i_dmem_ack) begin
                    if (w_is_sw) w_retire = 1'b1;
                    else         w_next_state = S_WB;
                end else if (w_timeout) begin
                    w_next_state = S_ERROR;
                end
            end
            S_WB: begin
                w_reg_we = 1'b1;
                w_retire = 1'b1;
            end
            S_ERROR: begin
                w_bus_error = 1'b1;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        if (w_retire) w_next_state = bus.i_run ? S_FETCH : S_IDLE;
    end

    // State register; reset drops any in-flight instruction straight to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Ack-less cycles in FETCH/MEM count up; anything else clears, so each access starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_wait_cnt <= '0;
        else if (w_in_wait && !w_ack) r_wait_cnt <= r_wait_cnt + 1'b1;
        else                         r_wait_cnt <= '0;
    end

    // Retired-instruction counter, free-running with natural wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_retired_cnt <= '0;
        else if (w_retire) r_retired_cnt <= r_retired_cnt + 1'b1;
    end

    assign bus.o_imem_req    = w_imem_req;
    assign bus.o_dmem_req    = w_dmem_req;
    assign bus.o_dmem_we     = w_dmem_we;
    assign bus.o_ir_we       = w_ir_we;
    assign bus.o_pc_inc      = w_pc_inc;
    assign bus.o_pc_branch   = w_pc_branch;
    assign bus.o_pc_jump     = w_pc_jump;
    assign bus.o_reg_we      = w_reg_we;
    assign bus.o_retired     = w_retire;
    assign bus.o_retired_cnt = r_retired_cnt;
    assign bus.o_bus_error   = w_bus_error;
    assign bus.o_state       = r_state;

endmodule
